// File: rtl/dh_shared_key_pkg.sv
// Shared types, default widths and the latency helper for the shared-key engine.
// The latency helper follows DH_CONST_TIME_EN so callers see the build's real timing.
package dh_pkg;

    localparam int DH_W     = 32;
    localparam int DH_EXP_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RED  = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        FIN  = 3'd4
    } dh_state_t;

    // Start edge to done pulse, in clock cycles, for a modulus p >= 2.
    function automatic int lat(input int w, input int exp_w, input logic [63:0] x);
        int ones;
        ones = 0;
        for (int k = 0; k < 64; k++) begin
            if ((k < exp_w) && x[k]) begin
                ones++;
            end
        end
`ifdef DH_CONST_TIME_EN
        ones = exp_w;
`endif
        return (w + 1) * (1 + exp_w + ones) + 2;
    endfunction

endpackage

// File: rtl/dh_shared_key_if.sv
// Request/result bundle between the key-exchange controller and the shared-key engine.
interface dh_shared_key_if
    import dh_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W
) ();

    logic             start;
    logic [W-1:0]     r2;
    logic [EXP_W-1:0] x;
    logic [W-1:0]     p;
    logic             busy;
    logic             done;
    logic [W-1:0]     key;
    logic             err;

    modport master (
        output start, r2, x, p,
        input  busy, done, key, err
    );

    modport slave (
        input  start, r2, x, p,
        output busy, done, key, err
    );

endinterface

// File: rtl/dh_shared_key_mod_mul.sv
// Interleaved shift-add modular multiplier: res = a*b mod p in exactly W+1 cycles.
// Requires a < p; the accumulator carries two guard bits so 2*acc + a never overflows.
module dh_mod_mul
    import dh_pkg::*;
#(
    parameter int W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         rdy,
    output logic [W-1:0] res
);

    localparam int CW = $clog2(W + 1);

    logic [W+1:0]  acc_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  p_reg;
    logic [CW-1:0] cnt_reg;
    logic          rdy_reg;

    logic [W+1:0]  sum_next;
    logic [W+1:0]  sub1_next;
    logic [W+1:0]  acc_next;
    logic [W+1:0]  p_wide;

    // 2*acc + a < 3p, so at most two conditional subtractions restore acc < p.
    always_comb begin
        p_wide    = {2'b00, p_reg};
        sum_next  = (acc_reg << 1) + (b_reg[W-1] ? {2'b00, a_reg} : '0);
        sub1_next = (sum_next >= p_wide) ? (sum_next - p_wide) : sum_next;
        acc_next  = (sub1_next >= p_wide) ? (sub1_next - p_wide) : sub1_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            p_reg   <= '0;
            cnt_reg <= '0;
            rdy_reg <= 1'b0;
        end else if (go) begin
            acc_reg <= '0;
            a_reg   <= a;
            b_reg   <= b;
            p_reg   <= p;
            cnt_reg <= CW'(W);
            rdy_reg <= 1'b0;
        end else if (cnt_reg != '0) begin
            acc_reg <= acc_next;
            b_reg   <= b_reg << 1;
            cnt_reg <= cnt_reg - CW'(1);
            rdy_reg <= (cnt_reg == CW'(1));
        end else begin
            rdy_reg <= 1'b0;
        end
    end

    assign rdy = rdy_reg;
    assign res = acc_reg[W-1:0];

endmodule

// File: rtl/dh_shared_key.sv
// Shared secret K = r2^x mod p by MSB-first square-and-multiply over one time-shared multiplier.
// Build option DH_CONST_TIME_EN: always run the multiply step so latency does not depend on x.
module dh_shared_key
    import dh_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W
) (
    input  logic            clk,
    input  logic            rst,
    dh_shared_key_if.slave  bus
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    dh_state_t        state_reg;
    dh_state_t        state_next;

    logic [W-1:0]     acc_reg;
    logic [W-1:0]     acc_next;
    logic [W-1:0]     base_reg;
    logic [W-1:0]     p_reg;
    logic [EXP_W-1:0] x_reg;
    logic [IW-1:0]    i_reg;
    logic             bad_p_reg;
    logic [W-1:0]     key_reg;
    logic             err_reg;
    logic             done_reg;

    logic             accept;
    logic             bad_p_now;
    logic             bit_now;
    logic             last_bit;
    logic             dec_i;
    logic             busy;

    logic             mm_go;
    logic [W-1:0]     mm_a;
    logic [W-1:0]     mm_b;
    logic [W-1:0]     mm_p;
    logic             mm_rdy;
    logic [W-1:0]     mm_res;

    assign accept    = (state_reg == IDLE) && bus.start;
    assign bad_p_now = (bus.p < W'(2));
    assign bit_now   = x_reg[i_reg];
    assign last_bit  = (i_reg == '0);

    dh_mod_mul #(
        .W (W)
    ) u_mod_mul (
        .clk (clk),
        .rst (rst),
        .go  (mm_go),
        .a   (mm_a),
        .b   (mm_b),
        .p   (mm_p),
        .rdy (mm_rdy),
        .res (mm_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = bad_p_now ? FIN : RED;
                end
            end
            RED: begin
                if (mm_rdy) begin
                    state_next = SQR;
                end
            end
            SQR: begin
                if (mm_rdy) begin
`ifdef DH_CONST_TIME_EN
                    state_next = MUL;
`else
                    if (bit_now) begin
                        state_next = MUL;
                    end else if (last_bit) begin
                        state_next = FIN;
                    end else begin
                        state_next = SQR;
                    end
`endif
                end
            end
            MUL: begin
                if (mm_rdy) begin
                    state_next = last_bit ? FIN : SQR;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The multiplier is launched on the same edge the FSM enters an operation state,
    // so its operands are the values the registers are about to take.
    always_comb begin
        busy     = (state_reg != IDLE);
        acc_next = acc_reg;
        unique case (state_reg)
            IDLE:    if (bus.start) acc_next = W'(1);
            SQR:     if (mm_rdy) acc_next = mm_res;
            MUL:     if (mm_rdy && bit_now) acc_next = mm_res;
            default: acc_next = acc_reg;
        endcase

        mm_go = (accept || mm_rdy) &&
                ((state_next == RED) || (state_next == SQR) || (state_next == MUL));
        dec_i = mm_rdy && (state_reg != RED) && (state_next == SQR);

        mm_a = acc_next;
        mm_b = acc_next;
        mm_p = p_reg;
        if (state_next == RED) begin
            mm_a = W'(1);
            mm_b = bus.r2;
            mm_p = bus.p;
        end else if (state_next == MUL) begin
            mm_b = base_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg   <= '0;
            base_reg  <= '0;
            p_reg     <= '0;
            x_reg     <= '0;
            i_reg     <= '0;
            bad_p_reg <= 1'b0;
            key_reg   <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            acc_reg  <= acc_next;
            if (accept) begin
                p_reg     <= bus.p;
                x_reg     <= bus.x;
                bad_p_reg <= bad_p_now;
                i_reg     <= IW'(EXP_W - 1);
                err_reg   <= 1'b0;
            end
            if ((state_reg == RED) && mm_rdy) begin
                base_reg <= mm_res;
            end
            if (dec_i) begin
                i_reg <= i_reg - IW'(1);
            end
            if (state_reg == FIN) begin
                done_reg <= 1'b1;
                err_reg  <= bad_p_reg;
                key_reg  <= bad_p_reg ? '0 : acc_reg;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_reg;
    assign bus.key  = key_reg;
    assign bus.err  = err_reg;

endmodule

// File: tb/tb_dh_shared_key.sv
// Bench for dh_shared_key: table vectors on a 32-bit instance, random pow-mod on a 16-bit one.
// Expected results are queued when a start is driven and checked when done pulses.
module tb_dh_shared_key;
    import dh_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dh_shared_key_if #(.W(32), .EXP_W(32)) bus32 ();
    dh_shared_key_if #(.W(16), .EXP_W(16)) bus16 ();

    dh_shared_key #(.W(32), .EXP_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    dh_shared_key #(.W(16), .EXP_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        logic [31:0] key;
        logic        err;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] r2;
        logic [31:0] x;
        logic [31:0] p;
        logic [31:0] key;
        logic        err;
        string       name;
    } vec_t;

    exp_t q32[$];
    exp_t q16[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m, input int ew);
        logic [63:0] r;
        logic [63:0] bb;
        if (m < 2) return 64'd0;
        r  = 64'd1;
        bb = b % m;
        for (int k = 0; k < ew; k++) begin
            if (e[k]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst && bus32.done) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut32 unexpected done: key=0x%0h, required no done", bus32.key);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check({e.name, " key"}, 64'(bus32.key), 64'(e.key));
                check({e.name, " err"}, 64'(bus32.err), 64'(e.err));
                check({e.name, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
                $display("dut32 %s: key=0x%08h err=%0b latency=%0d", e.name, bus32.key, bus32.err, cyc - e.t0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst && bus16.done) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut16 unexpected done: key=0x%0h, required no done", bus16.key);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check({e.name, " key"}, 64'(bus16.key), 64'(e.key));
                check({e.name, " err"}, 64'(bus16.err), 64'(e.err));
                check({e.name, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
                $display("dut16 %s: key=0x%04h err=%0b latency=%0d", e.name, bus16.key, bus16.err, cyc - e.t0);
            end
        end
    end

    task automatic go32(input logic [31:0] r2, input logic [31:0] x, input logic [31:0] p,
                        input logic [31:0] k, input logic er, input string nm);
        exp_t e;
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.r2 = r2;
        bus32.x  = x;
        bus32.p  = p;
        e.key = k;
        e.err = er;
        e.lat = (p < 32'd2) ? 2 : lat(32, 32, 64'(x));
        e.t0  = cyc;
        e.name = nm;
        q32.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
        bus32.r2 = $urandom;
        bus32.x  = $urandom;
        bus32.p  = $urandom;
        check({nm, " busy after start"}, 64'(bus32.busy), 64'd1);
    endtask

    task automatic go16(input logic [15:0] r2, input logic [15:0] x, input logic [15:0] p,
                        input string nm);
        exp_t e;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.r2 = r2;
        bus16.x  = x;
        bus16.p  = p;
        e.key = 32'(powmod(64'(r2), 64'(x), 64'(p), 16));
        e.err = (p < 16'd2);
        e.lat = (p < 16'd2) ? 2 : lat(16, 16, 64'(x));
        e.t0  = cyc;
        e.name = nm;
        q16.push_back(e);
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.r2 = 16'($urandom);
        bus16.x  = 16'($urandom);
        bus16.p  = 16'($urandom);
    endtask

    task automatic wait32(input int budget);
        int n;
        n = 0;
        while (q32.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dut32 results pending at timeout", 64'(q32.size()), 64'd0);
        q32.delete();
    endtask

    task automatic wait16(input int budget);
        int n;
        n = 0;
        while (q16.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dut16 results pending at timeout", 64'(q16.size()), 64'd0);
        q16.delete();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'd19, 32'd6, 32'd23, 32'd2, 1'b0, "v0 19^6 mod 23"};
        vecs[1] = '{32'd40, 32'd1, 32'd23, 32'd17, 1'b0, "v1 reduce 40"};
        vecs[2] = '{32'd46, 32'd5, 32'd23, 32'd0, 1'b0, "v2 multiple of p"};
        vecs[3] = '{32'd7, 32'd0, 32'd11, 32'd1, 1'b0, "v3 x=0"};
        vecs[4] = '{32'd5, 32'd3, 32'd1, 32'd0, 1'b1, "v4 p=1"};
        vecs[5] = '{32'd9, 32'd7, 32'd0, 32'd0, 1'b1, "v5 p=0"};
        vecs[6] = '{32'd46, 32'd0, 32'd23, 32'd1, 1'b0, "v6 multiple x=0"};
        vecs[7] = '{32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "v7 p max, -1 cubed"};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "v8 p max, r2=p"};
        vecs[9] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "v9 p max, 2^x"};

        bus32.start = 1'b0; bus32.r2 = '0; bus32.x = '0; bus32.p = '0;
        bus16.start = 1'b0; bus16.r2 = '0; bus16.x = '0; bus16.p = '0;

        repeat (3) @(negedge clk);
        check("reset busy32", 64'(bus32.busy), 64'd0);
        check("reset done32", 64'(bus32.done), 64'd0);
        check("reset key32", 64'(bus32.key), 64'd0);
        check("reset err32", 64'(bus32.err), 64'd0);
        check("reset busy16", 64'(bus16.busy), 64'd0);
        check("reset key16", 64'(bus16.key), 64'd0);
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            go32(vecs[v].r2, vecs[v].x, vecs[v].p, vecs[v].key, vecs[v].err, vecs[v].name);
            wait32(3000);
        end

        // A start while busy must be ignored; then restart the cycle after done.
        go32(32'd19, 32'd6, 32'd23, 32'd2, 1'b0, "s1 ignored restart");
        repeat (100) @(negedge clk);
        bus32.start = 1'b1; bus32.r2 = 32'd40; bus32.x = 32'd1; bus32.p = 32'd29;
        @(negedge clk);
        bus32.start = 1'b0;
        check("s1 busy after ignored start", 64'(bus32.busy), 64'd1);
        wait32(3000);
        go32(32'd40, 32'd1, 32'd23, 32'd17, 1'b0, "s2 back-to-back");
        wait32(3000);

        // Reset in the middle of the first squaring aborts without a done pulse.
        go32(32'd19, 32'd6, 32'd23, 32'd2, 1'b0, "s3 aborted");
        repeat (43) @(negedge clk);
        rst = 1'b0;
        #1;
        check("s3 busy in reset", 64'(bus32.busy), 64'd0);
        check("s3 done in reset", 64'(bus32.done), 64'd0);
        check("s3 key in reset", 64'(bus32.key), 64'd0);
        q32.delete();
        @(negedge clk);
        rst = 1'b1;
        go32(32'd19, 32'd6, 32'd23, 32'd2, 1'b0, "s4 after reset");
        wait32(3000);

        go16(16'hFFFF, 16'hFFFF, 16'hFFFF, "r p max r2=p");
        wait16(1000);
        go16(16'h0000, 16'h0000, 16'hFFFF, "r x=0 r2=0");
        wait16(1000);
        for (int n = 0; n < 20; n++) begin
            go16(16'($urandom), 16'($urandom), 16'($urandom_range(65535, 2)), $sformatf("r%0d", n));
            wait16(1000);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
